// File: rtl/ex_mem_stage.sv
// ex_mem_stage: registered EX->MEM pipeline boundary.
// Captures the ALU result, store data and control bits of each executed
// instruction into a 2-entry skid buffer (main + skid) and resolves
// conditional branches, issuing a one-cycle PC redirect for taken branches.
//
// Handshake: a beat moves across an interface on a rising clock edge when
// its valid and ready are both high. A producer holds valid and payload
// stable until that edge. ex_ready is decoded only from the state register,
// so it never depends combinationally on m_ready. The m_* outputs stay
// stable while m_valid is high and m_ready is low.
module ex_mem_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             zero_flag,
    input  logic [XLEN-1:0]  store_data,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic [RADDR-1:0] rd,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             reg_write,
    input  logic             mem_to_reg,
    input  logic             branch,
    input  logic [2:0]       branch_type,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [XLEN-1:0]  m_alu_result,
    output logic [XLEN-1:0]  m_store_data,
    output logic [RADDR-1:0] m_rd,
    output logic             m_mem_read,
    output logic             m_mem_write,
    output logic             m_reg_write,
    output logic             m_mem_to_reg,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]  alu_result;
        logic [XLEN-1:0]  store_data;
        logic [RADDR-1:0] rd;
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic             mem_to_reg;
    } payload_t;

    state_t   state;
    payload_t main_q;
    payload_t skid_q;
    payload_t in_beat;
    logic     acc;
    logic     pop;
    logic     taken;
    logic     redirect_now;

    assign in_beat  = {alu_result, store_data, rd, mem_read, mem_write, reg_write, mem_to_reg};

    // Skid entry full means no room for another beat this cycle.
    assign ex_ready = (state != TWO);
    assign m_valid  = (state != EMPTY);
    assign acc      = ex_valid & ex_ready & ~flush;
    assign pop      = m_valid & m_ready;

    assign dbg_state = state;

    assign m_alu_result = main_q.alu_result;
    assign m_store_data = main_q.store_data;
    assign m_rd         = main_q.rd;
    assign m_mem_read   = main_q.mem_read;
    assign m_mem_write  = main_q.mem_write;
    assign m_reg_write  = main_q.reg_write;
    assign m_mem_to_reg = main_q.mem_to_reg;

    // Branch condition from the ALU zero flag or the slt result bit.
    always_comb begin
        taken = 1'b0;
        case (branch_type)
            3'b000:  taken = zero_flag;
            3'b001:  taken = ~zero_flag;
            3'b100:  taken = alu_result[0];
            3'b101:  taken = ~alu_result[0];
            3'b110:  taken = alu_result[0];
            3'b111:  taken = ~alu_result[0];
            default: taken = 1'b0;
        endcase
    end

    assign redirect_now = acc & branch & taken;

    // Skid-buffer FSM: main feeds MEM, skid absorbs one beat of backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        main_q <= in_beat;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        main_q <= in_beat;
                    end else if (acc) begin
                        skid_q <= in_beat;
                        state  <= TWO;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // One-cycle redirect pulse; the target holds until the next taken branch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= redirect_now;
            if (redirect_now) begin
                redirect_pc <= pc + imm;
            end
        end
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Registered EX→MEM boundary of the RISC-V pipeline. It captures the ALU result, zero flag and control bundle of each executed instruction and resolves conditional branches from the ALU outputs. It issues a one-cycle PC redirect for taken branches and forwards a FIFO-ordered payload to the memory stage through a 2-entry skid buffer, so backpressure from MEM never drops or reorders instructions.

## Interface
- `XLEN`, 32, datapath width
- `RADDR`, 5, register-address width
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  reset, asynchronous assert, active-low
- `flush`  in  1  synchronous kill of all buffered and incoming instructions
- `ex_valid`  in  1  EX beat valid
- `ex_ready`  out  1  stage can accept a beat
- `alu_result`  in  XLEN  ALU result (slt-op result for `blt*`/`bge*`)
- `zero_flag`  in  1  ALU operand equality flag
- `store_data`  in  XLEN  rs2 value for stores
- `pc`, `imm`  in  XLEN each  instruction PC and branch offset
- `rd`  in  RADDR  destination register
- `mem_read`, `mem_write`, `reg_write`, `mem_to_reg`, `branch`  in  1 each  control bits
- `branch_type`  in  3  funct3 (000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu)
- `redirect_valid`  out  1  one-cycle taken-branch pulse
- `redirect_pc`  out  XLEN  branch target
- `m_valid`  out  1  MEM beat valid
- `m_ready`  in  1  MEM accepts beat
- `m_alu_result`, `m_store_data`  out  XLEN each; `m_rd`  out  RADDR; `m_mem_read`, `m_mem_write`, `m_reg_write`, `m_mem_to_reg`  out  1 each

## Operation
- `acc` = `ex_valid & ex_ready & !flush`. `pop` = `m_valid & m_ready`.
- Payload = {alu_result, store_data, rd, mem_read, mem_write, reg_write, mem_to_reg}; 73 bits at defaults.
- Storage: `main` entry drives `m_*`; `skid` entry holds overflow.
- States:
  - EMPTY (m_valid=0)
  - ONE (main valid)
  - TWO (main+skid valid)
- Transitions:
  - EMPTY: acc→ONE (main←in).
  - ONE: acc&pop→ONE (main←in); acc&!pop→TWO (skid←in); !acc&pop→EMPTY; else hold.
  - TWO: pop→ONE (main←skid); else hold. No accept is possible in TWO.
- `ex_ready` = (state≠TWO); decoded from the state register, never combinationally from `m_ready`.
- Branch taken, when `acc & branch`:
  - beq: zero_flag
  - bne: !zero_flag
  - blt/bltu: alu_result[0]
  - bge/bgeu: !alu_result[0]
  - Other `branch_type` codes: not taken.
- Taken branch: next cycle `redirect_valid`=1, `redirect_pc` = pc+imm (modulo 2^XLEN, wraps silently). Pulse lasts exactly one cycle.
- Branches still enter the payload path; a branch has reg_write=0, so it is a MEM no-op.
- `flush`:
  - Next state EMPTY.
  - Same-cycle EX beat discarded: no redirect, no payload.
  - A `redirect_valid` already on the output is unaffected.
  - A pop in the same cycle is still considered consumed by MEM.
- Order: MEM sees beats in exact acceptance order. No duplication, no loss.

## Timing
- Reset (reset_n=0, async):
  - State EMPTY; `m_valid`=0; `ex_ready`=1; `redirect_valid`=0.
  - `redirect_pc`=0; all `m_*` data/control outputs =0.
- Latency: beat accepted at edge N appears on `m_*` after edge N when the stage was EMPTY, or ONE with a pop at edge N. Redirect is high for the cycle after edge N.
- Throughput: 1 beat/cycle while `m_ready`=1.
- `m_*` hold stable while `m_valid & !m_ready`.
- Reset asserted mid-operation: everything clears immediately; contents are lost.

## Test plan
- Stream 4 add beats (results 0x10,0x20,0x30,0x40) with `m_ready`=1 → each appears 1 cycle later; `ex_ready` stays 1; `m_valid` high 4 cycles.
- Hold `m_ready`=0 while sending 3 beats → 2 accepted, `ex_ready`=0 after the 2nd. Release `m_ready` → outputs 0x10, 0x20, then 3rd beat accepted; order preserved.
- beq with zero_flag=1, pc=0x100, imm=0x20 → `redirect_valid` pulse one cycle, `redirect_pc`=0x120. bne with zero_flag=1 → no pulse.
- blt with alu_result=1 and pc=0xFFFFFFF0, imm=0x20 → redirect to 0x00000010 (wrap). bgeu with alu_result=1 → no redirect.
- State TWO, assert `flush` with `ex_valid`=1 (taken beq) → next cycle `m_valid`=0, `ex_ready`=1, no redirect.
- Drop `reset_n` asynchronously mid-stream → `m_valid`, `redirect_valid` go 0 without a clock edge; `ex_ready`=1.
